// File: rtl/fp32_pkg.sv
// Shared fp32 definitions for the sequential multiplier and divider:
// field widths, special encodings, FSM state type and field helpers.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;
    localparam int SIG_W  = MANT_W + 1;   // significand with hidden one
    localparam int ACC_W  = 2 * SIG_W;    // full product width
    localparam int CNT_W  = 5;            // enough to index SIG_W bits

    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_NORM = 2'd2
    } state_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
        return x[MANT_W+EXP_W-1:MANT_W];
    endfunction

    function automatic logic [MANT_W-1:0] fp_frac(input logic [31:0] x);
        return x[MANT_W-1:0];
    endfunction

    // Significand with the hidden one restored (denormals are handled as specials).
    function automatic logic [SIG_W-1:0] fp_sig(input logic [31:0] x);
        return {1'b1, x[MANT_W-1:0]};
    endfunction

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (fp_exp(x) == EXP_MAX) && (fp_frac(x) != '0);
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] x);
        return (fp_exp(x) == EXP_MAX) && (fp_frac(x) == '0);
    endfunction

    // Zero or denormal: both are flushed to zero by the datapath.
    function automatic logic fp_is_zero(input logic [31:0] x);
        return fp_exp(x) == '0;
    endfunction

endpackage

// File: rtl/fp_mant_shift_add.sv
// Radix-2 serial significand multiplier: one multiplier bit per step,
// adding the shifted multiplicand into a double-width accumulator.
module fp_mant_shift_add
    import fp32_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [SIG_W-1:0] ma,
    input  logic [SIG_W-1:0] mb,
    output logic [ACC_W-1:0] acc,
    output logic             last
);

    logic [SIG_W-1:0] ma_reg;
    logic [SIG_W-1:0] mb_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [ACC_W-1:0] addend;

    assign addend = ACC_W'(ma_reg) << cnt_reg;
    assign acc    = acc_reg;
    assign last   = (cnt_reg == CNT_W'(SIG_W - 1));

    // Load operands on start, otherwise accumulate one partial product per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_reg  <= '0;
            mb_reg  <= '0;
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (start) begin
            ma_reg  <= ma;
            mb_reg  <= mb;
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (step) begin
            if (mb_reg[cnt_reg]) begin
                acc_reg <= acc_reg + addend;
            end
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/multiplier_floating_seq.sv
// Sequential fp32 multiplier: FSM, special-case detection, normalisation and
// packing around the serial significand multiplier. Truncating rounding.
module multiplier_floating_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    state_t           state_reg;
    state_t           state_next;
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;
    logic             sign_reg;
    logic             done_reg;
    logic [31:0]      product_reg;
    logic             accept;
    logic             step;
    logic [ACC_W-1:0] acc;
    logic             last;
    logic [31:0]      result;

    assign accept  = (state_reg == ST_IDLE) && start;
    assign step    = (state_reg == ST_MUL);
    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign product = product_reg;

    fp_mant_shift_add u_mant (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .step  (step),
        .ma    (fp_sig(a)),
        .mb    (fp_sig(b)),
        .acc   (acc),
        .last  (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: fixed walk IDLE -> MUL (24 steps) -> NORM -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_MUL;
            ST_MUL:  if (last)  state_next = ST_NORM;
            ST_NORM: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture operands at accept; specials are judged from the captured copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sign_reg <= 1'b0;
        end else if (accept) begin
            a_reg    <= a;
            b_reg    <= b;
            sign_reg <= fp_sign(a) ^ fp_sign(b);
        end
    end

    // Normalise, compute exponent and apply special cases in priority order.
    always_comb begin
        logic              e_adj;
        logic [MANT_W-1:0] frac;
        logic signed [9:0] exp_sum;
        logic              nan_case;
        e_adj    = acc[ACC_W-1];
        frac     = e_adj ? acc[ACC_W-2:SIG_W] : acc[ACC_W-3:SIG_W-1];
        exp_sum  = {2'b00, fp_exp(a_reg)} + {2'b00, fp_exp(b_reg)}
                 + {9'd0, e_adj} - 10'(BIAS);
        nan_case = fp_is_nan(a_reg) || fp_is_nan(b_reg)
                || (fp_is_inf(a_reg) && fp_is_zero(b_reg))
                || (fp_is_inf(b_reg) && fp_is_zero(a_reg));
        if (nan_case) begin
            result = QNAN;
        end else if (fp_is_inf(a_reg) || fp_is_inf(b_reg)) begin
            result = {sign_reg, EXP_MAX, {MANT_W{1'b0}}};
        end else if (fp_is_zero(a_reg) || fp_is_zero(b_reg)) begin
            result = {sign_reg, 31'd0};
        end else if (exp_sum >= 10'sd255) begin
            result = {sign_reg, EXP_MAX, {MANT_W{1'b0}}};
        end else if (exp_sum <= 10'sd0) begin
            result = {sign_reg, 31'd0};
        end else begin
            result = {sign_reg, exp_sum[EXP_W-1:0], frac};
        end
    end

    // Output registers: done pulses for one cycle, product holds until the next done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            done_reg <= (state_reg == ST_NORM);
            if (state_reg == ST_NORM) begin
                product_reg <= result;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_floating_seq.sv
// Scoreboard bench for the sequential fp32 multiplier: stimulus pushes
// expected products, a monitor pops and checks them on every done.
module tb_multiplier_floating_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    typedef struct {
        logic [31:0] prod;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    multiplier_floating_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, req);
        end
    endtask

    // Monitor: product check on done, latency, pulse width and hold between dones.
    initial begin
        logic [31:0] last_prod;
        logic        prev_done;
        exp_t        e;
        last_prod = 32'd0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_prod = 32'd0;
                prev_done = 1'b0;
            end else begin
                if (done) begin
                    check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check({"prod_", e.name}, product, e.prod);
                        check({"lat_", e.name}, 32'(cyc - e.acc_cyc), 32'd25);
                        $display("op %s: product=%08h expected=%08h latency=%0d",
                                 e.name, product, e.prod, cyc - e.acc_cyc);
                    end
                    last_prod = product;
                end else begin
                    check("product_hold", product, last_prod);
                end
                prev_done = done;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] r, input string nm);
        exp_t e;
        wait_idle();
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.prod = r;
        e.acc_cyc = cyc;
        e.name = nm;
        sb.push_back(e);
        check({"busy_", nm}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n0;
        rst_n = 1'b0;
        start = 1'b0;
        a = 32'd0;
        b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_product", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        run_op(32'h40000000, 32'h40400000, 32'h40C00000, "2x3");
        run_op(32'h40800000, 32'h40F8A3D7, 32'h41F8A3D7, "4x7.77");
        run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, "1.5x1.5");
        run_op(32'hC0000000, 32'h3F000000, 32'hBF800000, "-2x0.5");
        run_op(32'h00000000, 32'h40A00000, 32'h00000000, "0x5");
        run_op(32'h7F000000, 32'h40000000, 32'h7F800000, "overflow");
        run_op(32'h7F800000, 32'h00000000, 32'h7FC00000, "infx0");
        run_op(32'h00800000, 32'h00800000, 32'h00000000, "underflow");
        run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan");
        run_op(32'hFF800000, 32'h40000000, 32'hFF800000, "-infx2");

        // Start held high: one accept per 26 clocks, operands changed while busy.
        wait_idle();
        @(negedge clk);
        a = 32'h40000000;
        b = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        e.prod = 32'h40C00000; e.acc_cyc = n0;      e.name = "held0"; sb.push_back(e);
        e.prod = 32'h40100000; e.acc_cyc = n0 + 26; e.name = "held1"; sb.push_back(e);
        e.prod = 32'h40100000; e.acc_cyc = n0 + 52; e.name = "held2"; sb.push_back(e);
        while (cyc < n0 + 10) begin @(posedge clk); #1; end
        a = 32'h3FC00000;
        b = 32'h3FC00000;
        while (cyc < n0 + 60) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_idle();

        // Reset mid-operation: aborted op must not produce a done.
        @(negedge clk);
        a = 32'h40000000;
        b = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n0 = cyc;
        while (cyc < n0 + 10) begin @(posedge clk); #1; end
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_product", product, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        run_op(32'h40000000, 32'h40400000, 32'h40C00000, "after_reset");

        wait_idle();
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
